// File: rtl/keysearch_scheduler.sv
// -----------------------------------------------------------------------------
// keysearch_scheduler
//
// Dynamic work scheduler for the DES key-search lane array. The 56-bit key
// space is cut into chunks of 2^CHUNK_BITS keys. Each idle lane raises
// lane_req and is handed the next chunk by a round-robin arbiter. The first
// lane_found hit is latched and stops the search. If every chunk has been
// handed out and all lanes are idle again without a hit, the search ends as
// exhausted.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start           level; a rising edge while idle begins a new search
//   abort           synchronous abort back to idle (wins over everything)
//   lane_req        per-lane "idle, give me a chunk"
//   lane_found      per-lane hit flag, meaningful while lane_run is high
//   lane_key        per-lane 64-bit key, lane i on bits [64i+63:64i]
//   lane_run        run enable for all lane counters (DISPATCH only)
//   lane_clear      one-cycle pulse clearing lane state (CLEAR only)
//   lane_grant      one-hot, one-cycle chunk assignment pulse
//   chunk_base      first key of the granted chunk, valid with lane_grant
//   busy            high in CLEAR and DISPATCH
//   found           high in FOUND
//   exhausted       high in EXHAUSTED
//   key             latched key of the winning lane
//   found_lane      index of the winning lane
//   chunks_issued   number of chunks granted since the last start
// -----------------------------------------------------------------------------
module keysearch_scheduler #(
    parameter int NUM_LANES   = 16,
    parameter int KEY_BITS    = 56,
    parameter int CHUNK_BITS  = 20,
    parameter int START_CHUNK = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_LANES-1:0]          lane_req,
    input  logic [NUM_LANES-1:0]          lane_found,
    input  logic [NUM_LANES*64-1:0]       lane_key,
    output logic                          lane_run,
    output logic                          lane_clear,
    output logic [NUM_LANES-1:0]          lane_grant,
    output logic [KEY_BITS-1:0]           chunk_base,
    output logic                          busy,
    output logic                          found,
    output logic                          exhausted,
    output logic [63:0]                   key,
    output logic [$clog2(NUM_LANES)-1:0]  found_lane,
    output logic [KEY_BITS-CHUNK_BITS:0]  chunks_issued
);

    localparam int CW = KEY_BITS - CHUNK_BITS;
    localparam int LW = $clog2(NUM_LANES);

    // Total number of chunks, held one bit wider than a chunk index so that
    // "all chunks issued" is representable.
    localparam logic [CW:0]   TOTAL     = {1'b1, {CW{1'b0}}};
    localparam logic [CW-1:0] START_IDX = CW'(START_CHUNK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DISPATCH,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t          state;
    state_t          state_n;

    logic            start_q;
    logic            start_rise;
    logic [LW-1:0]   rr_ptr;
    logic [CW-1:0]   next_chunk;

    logic [NUM_LANES-1:0] cand;
    logic            pick_hit;
    logic [LW-1:0]   pick_idx;

    logic            hit_any;
    logic [LW-1:0]   hit_idx;
    logic [63:0]     hit_key;

    logic            in_dispatch;
    logic            do_grant;
    logic            do_found;
    logic            all_done;

    assign start_rise = start & ~start_q;

    // Round-robin pick: first candidate at or above rr_ptr, with wraparound.
    // The lane granted last cycle is masked because it has not yet had a
    // chance to drop its request.
    always_comb begin
        int j;
        j        = 0;
        cand     = lane_req & ~lane_grant;
        pick_hit = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_LANES) begin
                j = j - NUM_LANES;
            end
            if (!pick_hit && cand[j]) begin
                pick_hit = 1'b1;
                pick_idx = LW'(j);
            end
        end
    end

    // Lowest-index hit wins; scanning downward leaves the lowest one last.
    always_comb begin
        hit_any = |lane_found;
        hit_idx = '0;
        hit_key = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_found[i]) begin
                hit_idx = LW'(i);
                hit_key = lane_key[64*i +: 64];
            end
        end
    end

    assign in_dispatch = (state == S_DISPATCH);
    assign do_found    = in_dispatch && !abort && hit_any;
    assign do_grant    = in_dispatch && !abort && !hit_any && pick_hit &&
                         (chunks_issued < TOTAL);
    // Space fully handed out, every lane back to requesting, and no grant
    // still in flight.
    assign all_done    = (chunks_issued == TOTAL) && (&lane_req) &&
                         (lane_grant == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        lane_run   = 1'b0;
        lane_clear = 1'b0;
        busy       = 1'b0;
        found      = 1'b0;
        exhausted  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                lane_clear = 1'b1;
                busy       = 1'b1;
                state_n    = S_DISPATCH;
            end
            S_DISPATCH: begin
                lane_run = 1'b1;
                busy     = 1'b1;
                if (hit_any) begin
                    state_n = S_FOUND;
                end else if (all_done) begin
                    state_n = S_EXHAUSTED;
                end
            end
            S_FOUND: begin
                found = 1'b1;
                if (!start) begin
                    state_n = S_IDLE;
                end
            end
            S_EXHAUSTED: begin
                exhausted = 1'b1;
                if (!start) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (abort) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q       <= 1'b0;
            rr_ptr        <= '0;
            next_chunk    <= START_IDX;
            chunks_issued <= '0;
            lane_grant    <= '0;
            chunk_base    <= '0;
            key           <= '0;
            found_lane    <= '0;
        end else begin
            start_q    <= start;
            lane_grant <= '0;
            if (state == S_IDLE && state_n == S_CLEAR) begin
                next_chunk    <= START_IDX;
                chunks_issued <= '0;
            end
            if (do_grant) begin
                lane_grant    <= NUM_LANES'(1) << pick_idx;
                chunk_base    <= {next_chunk, {CHUNK_BITS{1'b0}}};
                next_chunk    <= next_chunk + 1'b1;
                chunks_issued <= chunks_issued + 1'b1;
                rr_ptr        <= (int'(pick_idx) == NUM_LANES - 1) ? '0 : pick_idx + 1'b1;
            end
            if (do_found) begin
                key        <= hit_key;
                found_lane <= hit_idx;
            end
        end
    end

endmodule
